// File: rtl/serial_adder_ctrl_pkg.sv
// Shared constants for the nibble-serial adder sequencer.
// State encodings and nibble width used by the top and the adder.
package serial_adder_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/serial_adder_ctrl_adder.sv
// Single shared 4-bit adder used once per nibble pass.
// Pure combinational; carry in and carry out chain through the caller.
module adder_4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);

  logic [4:0] full;

  assign full   = {1'b0, a_i} + {1'b0, b_i} + {4'b0, cin_i};
  assign sum_o  = full[3:0];
  assign cout_o = full[4];

endmodule

// File: rtl/serial_adder_ctrl.sv
// Nibble-serial WIDTH-bit adder: one shared 4-bit adder, LSB nibble first,
// carry held in a register between passes; valid/ready on both sides.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = $clog2(NIBBLES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NIBBLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [NIBBLE_W-1:0] a_nib, b_nib, s_nib;
  logic                s_cout;

  assign a_nib = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
  assign b_nib = b_q[idx_q*NIBBLE_W +: NIBBLE_W];

  adder_4bit u_add (
    .a_i    (a_nib),
    .b_i    (b_nib),
    .cin_i  (carry_q),
    .sum_o  (s_nib),
    .cout_o (s_cout)
  );

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (1'b1)
      state_q == S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      state_q == S_RUN: begin
        sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = s_nib;
        carry_d = s_cout;
        if (idx_q == LAST_IDX) begin
          cout_d  = s_cout;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      state_q == S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=16.
// Expected sums are hand-computed constants.
module tb_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [15:0] a,
                       input logic [15:0] b, input logic cin,
                       input logic [15:0] es, input logic ec);
    int lat;
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    tick();
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    in_valid = 1'b0;
    in_a = ~a; in_b = ~b; in_cin = ~cin;
    wait_done(lat);
    chk({tag, "_lat"}, 32'(lat), 32'd4);
    chk({tag, "_sum"}, 32'(out_sum), 32'(es));
    chk({tag, "_cout"}, 32'(out_cout), 32'(ec));
    out_ready = 1'b1;
    tick();
    chk({tag, "_vld0"}, 32'(out_valid), 32'd0);
    out_ready = 1'b0;
  endtask

  logic [15:0] qa [3];
  logic [15:0] qb [3];
  logic        qc [3];
  logic [15:0] qs [3];
  logic        qo [3];

  initial begin
    int lat, na, nr, cyc;
    int acc_cyc [3];
    logic acc, fire;

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_cin = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_sum", 32'(out_sum), 32'h0);
    chk("rst_cout", 32'(out_cout), 32'd0);
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    do_op("t1", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    do_op("t2", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    do_op("t3", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);

    // Stall in DONE with a new request pending
    in_a = 16'h0001; in_b = 16'h0002; in_cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_done(lat);
    chk("t4_lat", 32'(lat), 32'd4);
    in_a = 16'h1111; in_b = 16'h2222; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_vld", 32'(out_valid), 32'd1);
      chk("t4_sum", 32'(out_sum), 32'h0003);
      chk("t4_cout", 32'(out_cout), 32'd0);
      chk("t4_rdy", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("t4_idle_rdy", 32'(in_ready), 32'd1);
    chk("t4_idle_busy", 32'(busy), 32'd0);
    out_ready = 1'b0;
    tick();
    chk("t4_acc", 32'(busy), 32'd1);
    in_valid = 1'b0;
    wait_done(lat);
    chk("t4b_sum", 32'(out_sum), 32'h3333);
    chk("t4b_cout", 32'(out_cout), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset while RUN at idx 2, carry register holding 1
    in_a = 16'hFFFF; in_b = 16'h0001; in_cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("t5_vld", 32'(out_valid), 32'd0);
    chk("t5_rdy", 32'(in_ready), 32'd1);
    chk("t5_sum", 32'(out_sum), 32'h0);
    #10;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t5_novld", 32'(out_valid), 32'd0);
    end
    do_op("t5b", 16'h0008, 16'h0008, 1'b0, 16'h0010, 1'b0);

    // Back-to-back operands with both handshakes held high
    qa[0] = 16'hABCD; qb[0] = 16'h1234; qc[0] = 1'b1; qs[0] = 16'hBE02; qo[0] = 1'b0;
    qa[1] = 16'h8000; qb[1] = 16'h8000; qc[1] = 1'b0; qs[1] = 16'h0000; qo[1] = 1'b1;
    qa[2] = 16'h0F0F; qb[2] = 16'hF0F0; qc[2] = 1'b1; qs[2] = 16'h0000; qo[2] = 1'b1;
    na = 0; nr = 0; cyc = 0;
    acc_cyc[0] = 0; acc_cyc[1] = 0; acc_cyc[2] = 0;
    in_a = qa[0]; in_b = qb[0]; in_cin = qc[0];
    in_valid = 1'b1; out_ready = 1'b1;
    while (nr < 3 && cyc < 60) begin
      acc  = in_valid && in_ready;
      fire = out_valid && out_ready;
      if (fire) begin
        chk("t6_sum", 32'(out_sum), 32'(qs[nr]));
        chk("t6_cout", 32'(out_cout), 32'(qo[nr]));
        nr++;
      end
      tick();
      cyc++;
      if (acc) begin
        acc_cyc[na] = cyc;
        na++;
        if (na < 3) begin
          in_a = qa[na]; in_b = qb[na]; in_cin = qc[na];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    chk("t6_nres", 32'(nr), 32'd3);
    chk("t6_nacc", 32'(na), 32'd3);
    chk("t6_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
    chk("t6_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd6);
    out_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
